// File: rtl/alsu_cmd_sequencer.sv
// ALSU command sequencer: FIFO-buffered command feeder with per-command repeat.
// Optional write-port command checking is enabled by defining ALSU_SEQ_CHECK_EN.
module alsu_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int REP_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [REP_W+15:0] cmd_data,
   output logic [2:0]        opcode,
   output logic [2:0]        A,
   output logic [2:0]        B,
   output logic              cin,
   output logic              serial_in,
   output logic              direction,
   output logic              red_op_A,
   output logic              red_op_B,
   output logic              bypass_A,
   output logic              bypass_B,
   output logic              issue,
   output logic              busy,
   output logic              err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = REP_W + 16;

   typedef enum logic {
      S_IDLE,
      S_ISSUE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_mem [FIFO_DEPTH];
   logic [PW:0]      r_wptr;
   logic [PW:0]      r_rptr;
   logic [15:0]      r_cmd;
   logic [REP_W-1:0] r_rep_cnt;
   logic [CW-1:0]    w_head;
   logic             w_empty;
   logic             w_full;
   logic             w_acc;
   logic             w_reject;
   logic             w_wr;
   logic             w_pop;
   logic             w_dec;
   logic             w_clear;

   // Extra wrap bit distinguishes full from empty when the low bits match
   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[PW] != r_rptr[PW]) &&
                      (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
   assign cmd_ready = !w_full;
   assign w_acc     = cmd_valid && !w_full;
   assign w_head    = r_mem[r_rptr[PW-1:0]];

`ifdef ALSU_SEQ_CHECK_EN
   logic r_err;

   assign w_reject = (cmd_data[15:14] == 2'b11) ||
                     ((cmd_data[3] | cmd_data[2]) &&
                      (cmd_data[15:13] > 3'd1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_err <= 1'b0;
      else     r_err <= w_acc && w_reject;
   end

   assign err = r_err;
`else
   assign w_reject = 1'b0;
   assign err      = 1'b0;
`endif

   assign w_wr = w_acc && !w_reject;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[PW-1:0]] <= cmd_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + (PW+1)'(1);
         if (w_pop) r_rptr <= r_rptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_dec       = 1'b0;
      w_clear     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (r_rep_cnt != '0) begin
               w_dec = 1'b1;
            end else if (!w_empty) begin
               w_pop = 1'b1;
            end else begin
               w_clear     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output fields are held registered; clearing them yields the NOP vector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmd     <= '0;
         r_rep_cnt <= '0;
      end else if (w_pop) begin
         r_cmd     <= w_head[15:0];
         r_rep_cnt <= w_head[CW-1:16];
      end else if (w_dec) begin
         r_rep_cnt <= r_rep_cnt - REP_W'(1);
      end else if (w_clear) begin
         r_cmd     <= '0;
         r_rep_cnt <= '0;
      end
   end

   assign {opcode, A, B, cin, serial_in, direction,
           red_op_A, red_op_B, bypass_A, bypass_B} = r_cmd;

   assign issue = (r_state == S_ISSUE);
   assign busy  = !w_empty || issue;

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// Randomized bench for alsu_cmd_sequencer against a queue-based reference model.
module tb_alsu_cmd_sequencer;

   localparam int DEPTH = 4;
   localparam int RW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [RW+15:0] cmd_data = '0;
   logic [2:0]    opcode, A, B;
   logic          cin, serial_in, direction;
   logic          red_op_A, red_op_B, bypass_A, bypass_B;
   logic          issue, busy, err;

   alsu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .REP_W(RW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .opcode(opcode), .A(A), .B(B),
      .cin(cin), .serial_in(serial_in), .direction(direction),
      .red_op_A(red_op_A), .red_op_B(red_op_B),
      .bypass_A(bypass_A), .bypass_B(bypass_B),
      .issue(issue), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference: pending queue plus the command currently on the pins
   logic [RW+15:0] q[$];
   bit             cur_v = 0;
   logic [RW+15:0] cur = '0;
   int             left = 0;
   bit             err_e = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [RW+15:0] mk(input int rep, input int op,
      input int a, input int b, input int lo7);
      logic [RW+15:0] d;
      d = {RW'(rep), 3'(op), 3'(a), 3'(b), 7'(lo7)};
      return d;
   endfunction

   function automatic bit rejected(input logic [RW+15:0] d);
`ifdef ALSU_SEQ_CHECK_EN
      int op;
      op = int'(d[15:13]);
      return (op >= 6) || ((d[3] | d[2]) && op > 1);
`else
      return (d[15:13] == 3'd0) && (d[15:13] != 3'd0);
`endif
   endfunction

   task automatic check_outs();
      logic [15:0] pins;
      pins = {opcode, A, B, cin, serial_in, direction,
              red_op_A, red_op_B, bypass_A, bypass_B};
      chk("issue", 32'(issue), 32'(cur_v));
      chk("pins", 32'(pins), cur_v ? 32'(cur[15:0]) : 32'd0);
      chk("busy", 32'(busy), 32'((q.size() > 0) || cur_v));
      chk("ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
      chk("err", 32'(err), 32'(err_e));
   endtask

   task automatic model_edge(input bit v, input logic [RW+15:0] d,
                             output bit acc);
      acc = v && (q.size() < DEPTH);
      if ((!cur_v || left == 0) && q.size() > 0) begin
         cur   = q.pop_front();
         cur_v = 1;
         left  = int'(cur[RW+15:16]);
      end else if (cur_v && left > 0) begin
         left--;
      end else begin
         cur_v = 0;
      end
      err_e = acc && rejected(d);
      if (acc && !rejected(d)) q.push_back(d);
   endtask

   // One clock: drive at negedge, check, update model at posedge
   task automatic step(input bit v, input logic [RW+15:0] d, output bit acc);
      cmd_valid = v;
      cmd_data  = d;
      check_outs();
      @(posedge clk);
      model_edge(v, d, acc);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(1'b0, '0, a);
   endtask

   task automatic push(input logic [RW+15:0] d);
      bit a;
      int n;
      a = 0;
      n = 0;
      while (!a && n < 64) begin
         step(1'b1, d, a);
         n++;
      end
      chk("push_accept", 32'(a), 32'd1);
   endtask

   task automatic hard_reset();
      rst = 1'b1;
      q.delete();
      cur_v = 0;
      left  = 0;
      err_e = 0;
      #1;
      check_outs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit a;
      @(negedge clk);
      hard_reset();

      // Single-shot command, then NOP
      push(mk(0, 2, 3, 1, 7'b1000000));
      idle(4);

      // Shift with 6 issue cycles
      push(mk(5, 4, 5, 2, 7'b0110000));
      idle(9);

      // Long hold then overfill the FIFO
      push(mk(15, 1, 7, 7, 7'b0000001));
      idle(2);
      for (int i = 0; i < 5; i++) push(mk(i % 3, i, i, 7 - i, i * 5));
      idle(30);

      // Simultaneous push and pop around pointer wrap
      push(mk(3, 0, 1, 2, 3));
      for (int i = 0; i < 10; i++) push(mk(0, 5, i % 8, i % 5, i));
      idle(20);

      // Reset during a repeat with entries queued
      push(mk(7, 3, 2, 2, 0));
      push(mk(0, 1, 1, 1, 1));
      push(mk(0, 2, 2, 2, 2));
      idle(4);
      hard_reset();
      idle(6);

`ifdef ALSU_SEQ_CHECK_EN
      push(mk(0, 6, 1, 1, 0));
      idle(1);
      push(mk(0, 3, 1, 1, 7'b0001000));
      idle(1);
      push(mk(0, 1, 1, 1, 7'b0000100));
      idle(5);
`endif

      for (int i = 0; i < 1500; i++) begin
         logic [RW+15:0] d;
         d = RW'(0) == RW'(1) ? '0 : {RW'(0), 16'($urandom)};
         if ($urandom_range(0, 7) == 0)
            d[RW+15:16] = RW'($urandom);
         else
            d[RW+15:16] = RW'($urandom_range(0, 2));
         if (i % 400 == 399) hard_reset();
         else step(1'($urandom_range(0, 1)), d, a);
      end
      idle(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
